// File: rtl/pulsador_pkg.sv
// pulsador_pkg: shared types and constants for the button debouncer
package pulsador_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        CHK_HI    = 2'd1,
        STABLE_HI = 2'd2,
        CHK_LO    = 2'd3
    } ch_state_t;

    localparam int CH_A     = 0;
    localparam int CH_B     = 1;
    localparam int CH_OP    = 2;
    localparam int CH_RESET = 3;

    localparam int DEB_CYCLES_DEFAULT = 1000000;

endpackage

// File: rtl/pulsador_debouncer_channel.sv
// debounce_channel: 2-flop synchroniser plus debounce FSM for one button, emits a rise pulse (DEBOUNCE_BYPASS_EN skips the debounce)
module debounce_channel
    import pulsador_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
    parameter int CNT_W      = 20
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic rise_pulse,
    output logic checking
);

    logic s1, s2;

    // two-flop synchroniser for the asynchronous button
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

`ifdef DEBOUNCE_BYPASS_EN
    logic lvl;

    // stable level follows the synchronised level directly
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lvl        <= 1'b0;
            rise_pulse <= 1'b0;
        end else begin
            lvl        <= s2;
            rise_pulse <= s2 & ~lvl;
        end
    end

    assign checking = 1'b0;
`else
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEB_CYCLES - 1);

    ch_state_t        state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             rise_nx;

    // state, counter and registered rise pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= STABLE_LO;
            cnt        <= '0;
            rise_pulse <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            rise_pulse <= rise_nx;
        end
    end

    // a level change is accepted only after DEB_CYCLES consecutive agreeing samples
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        rise_nx  = 1'b0;
        case (state)
            STABLE_LO: if (s2) begin
                state_nx = CHK_HI;
                cnt_nx   = '0;
            end
            CHK_HI: if (!s2) state_nx = STABLE_LO;
                else if (cnt == LAST) begin
                    state_nx = STABLE_HI;
                    rise_nx  = 1'b1;
                end else cnt_nx = cnt + 1'b1;
            STABLE_HI: if (!s2) begin
                state_nx = CHK_LO;
                cnt_nx   = '0;
            end
            CHK_LO: if (s2) state_nx = STABLE_HI;
                else if (cnt == LAST) state_nx = STABLE_LO;
                else cnt_nx = cnt + 1'b1;
            default: state_nx = STABLE_LO;
        endcase
    end

    assign checking = (state == CHK_HI) || (state == CHK_LO);
`endif

endmodule

// File: rtl/pulsador_debouncer.sv
// pulsador_debouncer: debounces buttons into prioritised one-hot strobes with a frozen data bus (DEBOUNCE_BYPASS_EN skips debounce)
module pulsador_debouncer
    import pulsador_pkg::*;
#(
    parameter int NBITS      = 8,
    parameter int N_SEL      = 3,
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
    parameter int CNT_W      = 20
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_SEL-1:0] pulsador_raw,
    input  logic             btn_Reset_raw,
    input  logic [NBITS-1:0] entrada_raw,
    output logic [N_SEL-1:0] pulsador,
    output logic             btn_Reset,
    output logic [NBITS-1:0] entrada,
    output logic             busy
);

    localparam int NCH = N_SEL + 1;

    logic [NCH-1:0]   raw, rise, chk, pending, strobe, req, grant;
    logic [N_SEL-1:0] sel_req;
    logic [NBITS-1:0] e1, e2;

    assign raw = {btn_Reset_raw, pulsador_raw};

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        debounce_channel #(
            .DEB_CYCLES(DEB_CYCLES),
            .CNT_W     (CNT_W)
        ) u_ch (
            .clk       (clk),
            .reset_n   (reset_n),
            .raw       (raw[g]),
            .rise_pulse(rise[g]),
            .checking  (chk[g])
        );
    end

    // reset button wins, then the lowest-numbered select button
    always_comb begin
        req     = pending | rise;
        sel_req = req[N_SEL-1:0];
        grant   = req[N_SEL] ? {1'b1, {N_SEL{1'b0}}} : {1'b0, sel_req & (~sel_req + N_SEL'(1))};
    end

    // one registered strobe per cycle; ungranted requests stay pending
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= '0;
            strobe  <= '0;
        end else begin
            pending <= req & ~grant;
            strobe  <= grant;
        end
    end

    // data synchroniser; output freezes while anything is pending or strobing
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e1      <= '0;
            e2      <= '0;
            entrada <= '0;
        end else begin
            e1 <= entrada_raw;
            e2 <= e1;
            if (!(|pending) && !(|strobe)) entrada <= e2;
        end
    end

    assign pulsador  = strobe[N_SEL-1:0];
    assign btn_Reset = strobe[N_SEL];
    assign busy      = |{pending, chk, strobe};

endmodule

// File: tb/tb_pulsador_debouncer.sv
// tb_pulsador_debouncer: directed self-checking bench for pulsador_debouncer
module tb_pulsador_debouncer;

    localparam int DEB = 4;
`ifdef DEBOUNCE_BYPASS_EN
    localparam bit BYP = 1'b1;
    localparam int LAT = 4;
`else
    localparam bit BYP = 1'b0;
    localparam int LAT = DEB + 4;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] pulsador_raw;
    logic       btn_Reset_raw;
    logic [7:0] entrada_raw;
    logic [2:0] pulsador;
    logic       btn_Reset;
    logic [7:0] entrada;
    logic       busy;

    int checks = 0;
    int errors = 0;

    pulsador_debouncer #(
        .NBITS(8), .N_SEL(3), .DEB_CYCLES(DEB), .CNT_W(3)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pulsador_raw (pulsador_raw),
        .btn_Reset_raw(btn_Reset_raw),
        .entrada_raw  (entrada_raw),
        .pulsador     (pulsador),
        .btn_Reset    (btn_Reset),
        .entrada      (entrada),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        pulsador_raw = '0;
        btn_Reset_raw = 1'b0;
        entrada_raw = '0;
        #1;
        chk("reset_outputs", {pulsador, btn_Reset, entrada, busy}, '0);
        tick();
        tick();
        reset_n = 1'b1;
        for (int t = 0; t < 10; t++) begin
            tick();
            chk("idle_outputs", {pulsador, btn_Reset, entrada, busy}, '0);
        end

        entrada_raw = 8'h5A;
        pulsador_raw[0] = 1'b1;
        for (int t = 1; t <= LAT + 6; t++) begin
            tick();
            chk("a_strobe", {btn_Reset, pulsador}, (t == LAT) ? 32'h1 : 32'h0);
            if (t == LAT) chk("a_data", entrada, 32'h5A);
        end
        pulsador_raw[0] = 1'b0;
        for (int t = 1; t <= 12; t++) begin
            tick();
            chk("a_release", {btn_Reset, pulsador}, 32'h0);
        end
        chk("a_idle_busy", busy, 32'h0);

        pulsador_raw[1] = 1'b1;
        tick();
        tick();
        tick();
        chk("glitch_busy", busy, BYP ? 32'h0 : 32'h1);
        pulsador_raw[1] = 1'b0;
        for (int t = 4; t <= 15; t++) begin
            tick();
            chk("glitch_strobe", {btn_Reset, pulsador}, (BYP && t == LAT) ? 32'h2 : 32'h0);
        end
        chk("glitch_busy_end", busy, 32'h0);

        btn_Reset_raw = 1'b1;
        pulsador_raw[2] = 1'b1;
        for (int t = 1; t < LAT; t++) tick();
        tick();
        chk("rst_strobe", {btn_Reset, pulsador}, 32'h8);
        chk("rst_data", entrada, 32'h5A);
        entrada_raw = 8'hFF;
        tick();
        chk("op_strobe", {btn_Reset, pulsador}, 32'h4);
        chk("op_data", entrada, 32'h5A);
        chk("op_busy", busy, 32'h1);
        tick();
        chk("op_after", {btn_Reset, pulsador}, 32'h0);
        chk("hold_data", entrada, 32'h5A);
        tick();
        chk("new_data", entrada, 32'hFF);
        btn_Reset_raw = 1'b0;
        pulsador_raw[2] = 1'b0;
        for (int t = 0; t < 12; t++) tick();
        chk("op_idle_busy", busy, 32'h0);

        pulsador_raw[1:0] = 2'b11;
        for (int t = 1; t < LAT; t++) tick();
        tick();
        chk("pri_a_first", {btn_Reset, pulsador}, 32'h1);
        tick();
        chk("pri_b_second", {btn_Reset, pulsador}, 32'h2);
        tick();
        chk("pri_none", {btn_Reset, pulsador}, 32'h0);
        pulsador_raw[1:0] = 2'b00;
        for (int t = 0; t < 12; t++) tick();

        pulsador_raw[0] = 1'b1;
        for (int t = 0; t < 5; t++) tick();
        chk("pre_reset_busy", busy, BYP ? 32'h0 : 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset", {pulsador, btn_Reset, entrada, busy}, '0);
        tick();
        tick();
        reset_n = 1'b1;
        for (int t = 1; t <= LAT + 2; t++) begin
            tick();
            chk("post_reset_strobe", {btn_Reset, pulsador}, (t == LAT) ? 32'h1 : 32'h0);
        end
        pulsador_raw[0] = 1'b0;
        for (int t = 0; t < 12; t++) tick();
        chk("final_busy", busy, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
